// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32I write-back stage: load extraction, load-hold across stalls, register file, forwarding
//
// Purpose:
//   Takes memory-access results one cycle after the data RAM read, extracts and
//   sign/zero-extends load data, holds the raw load word across cache-miss
//   stalls, writes the 31x32 integer register file (x0 reads as zero) and
//   drives current and one-cycle-delayed forwarding buses for EX.
//
// Optional feature macro: WB_REGFILE_BYPASS_EN
//   Defined   : read ports return the value being written this cycle when the
//               addresses match (write-through).
//   Undefined : read ports return stored contents only.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_ld_wb, ld_code_wb         load flag and funct3 of the WB instruction
//   rd_adr_wb, rd_data_wb         destination register, ALU result / load address
//   wbk_rd_reg_wb                 write-back request
//   ld_data_wb                    raw word from data RAM / IO
//   stall, stall_1shot, stall_dly stall level, first stall cycle, delayed stall
//   rst_pipe_wb                   WB flush
//   inst_rs1_id, inst_rs2_id      ID read addresses
//   rs1_data_id, rs2_data_id      ID read data (combinational)
//   dbg_radr, dbg_rdata           debug read port (combinational)
//   wbk_en_fwd, rd_adr_fwd, rd_data_fwd        current write-back forwarding
//   wbk_en_fwd_d, rd_adr_fwd_d, rd_data_fwd_d  forwarding delayed by one cycle

module wb_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_ld_wb,
   input  logic [2:0]  ld_code_wb,
   input  logic [4:0]  rd_adr_wb,
   input  logic [31:0] rd_data_wb,
   input  logic        wbk_rd_reg_wb,
   input  logic [31:0] ld_data_wb,
   input  logic        stall,
   input  logic        stall_1shot,
   input  logic        stall_dly,
   input  logic        rst_pipe_wb,
   input  logic [4:0]  inst_rs1_id,
   input  logic [4:0]  inst_rs2_id,
   output logic [31:0] rs1_data_id,
   output logic [31:0] rs2_data_id,
   input  logic [4:0]  dbg_radr,
   output logic [31:0] dbg_rdata,
   output logic        wbk_en_fwd,
   output logic [4:0]  rd_adr_fwd,
   output logic [31:0] rd_data_fwd,
   output logic        wbk_en_fwd_d,
   output logic [4:0]  rd_adr_fwd_d,
   output logic [31:0] rd_data_fwd_d
);

   logic [31:0] ld_roll;
   logic [31:0] ld_raw;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] ld_ext;
   logic [31:0] wb_value;
   logic        we;
   logic [31:0] regs [0:31];

   // stall is already folded into wbk_rd_reg_wb upstream; kept on the port for pipeline symmetry
   logic        unused_stall;
   assign unused_stall = stall;

   // Raw load word captured on the first stall cycle, replayed while stall_dly is high
   always_ff @(posedge clk) begin
      if (rst || rst_pipe_wb)
         ld_roll <= 32'd0;
      else if (stall_1shot)
         ld_roll <= ld_data_wb;
   end

   assign ld_raw   = stall_dly ? ld_roll : ld_data_wb;
   assign byte_sel = ld_raw[{rd_data_wb[1:0], 3'b000} +: 8];
   assign half_sel = ld_raw[{rd_data_wb[1], 4'b0000} +: 16];

   always_comb begin
      ld_ext = 32'd0;
      case (ld_code_wb)
         3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
         3'b010:  ld_ext = ld_raw;
         3'b100:  ld_ext = {24'd0, byte_sel};
         3'b101:  ld_ext = {16'd0, half_sel};
         default: ld_ext = 32'd0;
      endcase
   end

   assign wb_value = cmd_ld_wb ? ld_ext : rd_data_wb;
   assign we       = wbk_rd_reg_wb & (rd_adr_wb != 5'd0) & ~rst_pipe_wb & ~rst;

   // No reset on the array so it can map onto distributed/block RAM
   always_ff @(posedge clk) begin
      if (we)
         regs[rd_adr_wb] <= wb_value;
   end

`ifdef WB_REGFILE_BYPASS_EN
   assign rs1_data_id = (inst_rs1_id == 5'd0) ? 32'd0 :
                        (we && (inst_rs1_id == rd_adr_wb)) ? wb_value : regs[inst_rs1_id];
   assign rs2_data_id = (inst_rs2_id == 5'd0) ? 32'd0 :
                        (we && (inst_rs2_id == rd_adr_wb)) ? wb_value : regs[inst_rs2_id];
   assign dbg_rdata   = (dbg_radr == 5'd0) ? 32'd0 :
                        (we && (dbg_radr == rd_adr_wb)) ? wb_value : regs[dbg_radr];
`else
   assign rs1_data_id = (inst_rs1_id == 5'd0) ? 32'd0 : regs[inst_rs1_id];
   assign rs2_data_id = (inst_rs2_id == 5'd0) ? 32'd0 : regs[inst_rs2_id];
   assign dbg_rdata   = (dbg_radr == 5'd0) ? 32'd0 : regs[dbg_radr];
`endif

   assign wbk_en_fwd  = we;
   assign rd_adr_fwd  = rd_adr_wb;
   assign rd_data_fwd = wb_value;

   // Delayed forwarding advances every cycle, stalled or not
   always_ff @(posedge clk) begin
      if (rst || rst_pipe_wb) begin
         wbk_en_fwd_d  <= 1'b0;
         rd_adr_fwd_d  <= 5'd0;
         rd_data_fwd_d <= 32'd0;
      end else begin
         wbk_en_fwd_d  <= wbk_en_fwd;
         rd_adr_fwd_d  <= rd_adr_fwd;
         rd_data_fwd_d <= rd_data_fwd;
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage

module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_ld_wb;
   logic [2:0]  ld_code_wb;
   logic [4:0]  rd_adr_wb;
   logic [31:0] rd_data_wb;
   logic        wbk_rd_reg_wb;
   logic [31:0] ld_data_wb;
   logic        stall;
   logic        stall_1shot;
   logic        stall_dly;
   logic        rst_pipe_wb;
   logic [4:0]  inst_rs1_id;
   logic [4:0]  inst_rs2_id;
   logic [31:0] rs1_data_id;
   logic [31:0] rs2_data_id;
   logic [4:0]  dbg_radr;
   logic [31:0] dbg_rdata;
   logic        wbk_en_fwd;
   logic [4:0]  rd_adr_fwd;
   logic [31:0] rd_data_fwd;
   logic        wbk_en_fwd_d;
   logic [4:0]  rd_adr_fwd_d;
   logic [31:0] rd_data_fwd_d;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .rst(rst), .cmd_ld_wb(cmd_ld_wb), .ld_code_wb(ld_code_wb),
      .rd_adr_wb(rd_adr_wb), .rd_data_wb(rd_data_wb), .wbk_rd_reg_wb(wbk_rd_reg_wb),
      .ld_data_wb(ld_data_wb), .stall(stall), .stall_1shot(stall_1shot),
      .stall_dly(stall_dly), .rst_pipe_wb(rst_pipe_wb),
      .inst_rs1_id(inst_rs1_id), .inst_rs2_id(inst_rs2_id),
      .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id),
      .dbg_radr(dbg_radr), .dbg_rdata(dbg_rdata),
      .wbk_en_fwd(wbk_en_fwd), .rd_adr_fwd(rd_adr_fwd), .rd_data_fwd(rd_data_fwd),
      .wbk_en_fwd_d(wbk_en_fwd_d), .rd_adr_fwd_d(rd_adr_fwd_d), .rd_data_fwd_d(rd_data_fwd_d)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      cmd_ld_wb = 0; ld_code_wb = 3'b000; rd_adr_wb = 0; rd_data_wb = 0;
      wbk_rd_reg_wb = 0; ld_data_wb = 0; stall = 0; stall_1shot = 0;
      stall_dly = 0; rst_pipe_wb = 0;
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic ld, input logic [2:0] code, input logic [4:0] adr,
                     input logic [31:0] dat, input logic [31:0] ram);
      idle();
      cmd_ld_wb = ld; ld_code_wb = code; rd_adr_wb = adr; rd_data_wb = dat;
      wbk_rd_reg_wb = 1; ld_data_wb = ram;
      #1;
   endtask

   initial begin
      idle();
      inst_rs1_id = 0; inst_rs2_id = 0; dbg_radr = 0;
      rst = 1;
      tick();
      tick();
      // write request during reset must not be enabled
      wbk_rd_reg_wb = 1; rd_adr_wb = 5'd4; rd_data_wb = 32'h44;
      #1;
      chk("rst_we", {31'd0, wbk_en_fwd}, 32'd0);
      chk("rst_en_d", {31'd0, wbk_en_fwd_d}, 32'd0);
      chk("rst_adr_d", {27'd0, rd_adr_fwd_d}, 32'd0);
      chk("rst_data_d", rd_data_fwd_d, 32'd0);
      tick();
      rst = 0;

      // Load extraction
      wr(1, 3'b000, 5'd5, 32'h103, 32'h80FF1234);
      chk("lb_fwd", rd_data_fwd, 32'hFFFFFF80);
      chk("lb_we", {31'd0, wbk_en_fwd}, 32'd1);
      tick();
      wr(1, 3'b100, 5'd6, 32'h103, 32'h80FF1234);
      tick();
      wr(1, 3'b001, 5'd10, 32'h102, 32'h80FF1234);
      tick();
      wr(1, 3'b101, 5'd11, 32'h102, 32'h80FF1234);
      tick();
      wr(1, 3'b000, 5'd13, 32'h100, 32'h80FF1234);
      tick();
      wr(1, 3'b001, 5'd14, 32'h100, 32'h80FF9234);
      tick();
      wr(1, 3'b011, 5'd15, 32'h100, 32'h80FF1234);
      chk("code011", rd_data_fwd, 32'd0);
      tick();
      idle();
      inst_rs1_id = 5; inst_rs2_id = 6; dbg_radr = 10;
      #1;
      chk("lb_x5", rs1_data_id, 32'hFFFFFF80);
      chk("lbu_x6", rs2_data_id, 32'h00000080);
      chk("lh_x10", dbg_rdata, 32'hFFFF80FF);
      inst_rs1_id = 11; inst_rs2_id = 13; dbg_radr = 14;
      #1;
      chk("lhu_x11", rs1_data_id, 32'h000080FF);
      chk("lb0_x13", rs2_data_id, 32'h00000034);
      chk("lh0_x14", dbg_rdata, 32'hFFFF9234);

      // ALU write and delayed forwarding
      wr(0, 3'b000, 5'd7, 32'hDEADBEEF, 32'h0);
      tick();
      idle();
      inst_rs1_id = 7;
      #1;
      chk("alu_x7", rs1_data_id, 32'hDEADBEEF);
      chk("alu_data_d", rd_data_fwd_d, 32'hDEADBEEF);
      chk("alu_adr_d", {27'd0, rd_adr_fwd_d}, 32'd7);
      chk("alu_en_d", {31'd0, wbk_en_fwd_d}, 32'd1);

      // x0 protection
      wr(0, 3'b000, 5'd0, 32'h12345678, 32'h0);
      chk("x0_we", {31'd0, wbk_en_fwd}, 32'd0);
      tick();
      idle();
      inst_rs2_id = 0;
      #1;
      chk("x0_read", rs2_data_id, 32'd0);
      chk("x0_en_d", {31'd0, wbk_en_fwd_d}, 32'd0);

      // Stall hold: capture on stall_1shot, replay on stall_dly
      idle();
      cmd_ld_wb = 1; ld_code_wb = 3'b010; rd_adr_wb = 12; rd_data_wb = 32'h200;
      ld_data_wb = 32'hCAFEF00D; stall = 1; stall_1shot = 1;
      tick();
      stall_1shot = 0; stall_dly = 1; ld_data_wb = 32'h0; wbk_rd_reg_wb = 1;
      #1;
      chk("hold_fwd", rd_data_fwd, 32'hCAFEF00D);
      tick();
      // simultaneous capture and replay: old value replayed, new one next cycle
      stall_1shot = 1; stall_dly = 1; ld_data_wb = 32'h11111111; wbk_rd_reg_wb = 0;
      #1;
      chk("both_old", rd_data_fwd, 32'hCAFEF00D);
      tick();
      stall_1shot = 0; ld_data_wb = 32'h0;
      #1;
      chk("both_new", rd_data_fwd, 32'h11111111);
      idle();
      inst_rs1_id = 12;
      #1;
      chk("hold_x12", rs1_data_id, 32'hCAFEF00D);

      // Flush
      wr(0, 3'b000, 5'd3, 32'h33, 32'h0);
      tick();
      wr(0, 3'b000, 5'd3, 32'h55, 32'h0);
      rst_pipe_wb = 1;
      #1;
      chk("flush_we", {31'd0, wbk_en_fwd}, 32'd0);
      tick();
      idle();
      dbg_radr = 3;
      #1;
      chk("flush_x3", dbg_rdata, 32'h33);
      chk("flush_data_d", rd_data_fwd_d, 32'd0);
      chk("flush_adr_d", {27'd0, rd_adr_fwd_d}, 32'd0);
      chk("flush_en_d", {31'd0, wbk_en_fwd_d}, 32'd0);
      // flush also cleared the held load word
      cmd_ld_wb = 1; ld_code_wb = 3'b010; stall_dly = 1; ld_data_wb = 32'hFFFFFFFF;
      #1;
      chk("flush_roll", rd_data_fwd, 32'd0);
      tick();

      // Same-cycle read of a register being written
      wr(0, 3'b000, 5'd9, 32'h1, 32'h0);
      tick();
      wr(0, 3'b000, 5'd9, 32'hA5A5A5A5, 32'h0);
      inst_rs1_id = 9;
      #1;
`ifdef WB_REGFILE_BYPASS_EN
      chk("byp_same", rs1_data_id, 32'hA5A5A5A5);
`else
      chk("byp_same", rs1_data_id, 32'h00000001);
`endif
      tick();
      idle();
      #1;
      chk("byp_next", rs1_data_id, 32'hA5A5A5A5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
